// File: rtl/jackpot_pkg.sv
// Shared types and default timing constants for the jackpot LED game.
package jackpot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } state_t;

  typedef logic [31:0] tick_cnt_t;

  localparam tick_cnt_t TC_SPIN_DEF    = 32'd12_500_000;
  localparam tick_cnt_t TC_SHOW_DEF    = 32'd31_250_000;
  localparam tick_cnt_t SHOW_TICKS_DEF = 32'd6;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/jackpot_if.sv
// Player-facing signal bundle: start button, switches, LEDs and status.
interface jackpot_if #(
  parameter int unsigned NLED = 4
);
  logic            START;
  logic [NLED-1:0] SWITCHES;
  logic [NLED-1:0] LEDS;
  logic            WIN;
  logic            BUSY;

  // Board / stimulus side.
  modport master (
    output START, SWITCHES,
    input  LEDS, WIN, BUSY
  );

  // Controller side.
  modport slave (
    input  START, SWITCHES,
    output LEDS, WIN, BUSY
  );
endinterface

// File: rtl/jackpot_tick_gen.sv
// Programmable single-cycle enable tick generator.
module tick_gen
  import jackpot_pkg::*;
(
  input  logic      CLOCK,
  input  logic      RESET,
  input  logic      clr,
  input  tick_cnt_t tc,
  output logic      tick
);

  tick_cnt_t cnt;
  logic      at_end;

  // Terminal count reached; tc of 0 or 1 ticks every cycle.
  always_comb begin
    at_end = (tc <= 32'd1) || (cnt >= tc - 32'd1);
    tick   = !clr && at_end;
  end

  // Count up, wrap on tick, force to zero on clear.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/jackpot_controller.sv
// Jackpot game sequencer: spin a lit LED, judge a switch press, show win/lose.
module jackpot_controller
  import jackpot_pkg::*;
#(
  parameter int unsigned NLED       = 4,
  parameter tick_cnt_t   TC_SPIN    = TC_SPIN_DEF,
  parameter tick_cnt_t   TC_SHOW    = TC_SHOW_DEF,
  parameter tick_cnt_t   SHOW_TICKS = SHOW_TICKS_DEF
) (
  input logic       CLOCK,
  input logic       RESET,
  jackpot_if.slave  io
);

  state_t          state;
  logic            start_q;
  logic [NLED-1:0] sw_q;
  logic            start_rise;
  logic [NLED-1:0] sw_rise;
  logic            hit;
  logic            clr;
  logic            tick;
  tick_cnt_t       tc;
  tick_cnt_t       show_cnt;
  logic [NLED-1:0] leds;
  logic            win_r;
  logic            busy_r;

  assign io.LEDS = leds;
  assign io.WIN  = win_r;
  assign io.BUSY = busy_r;

  // Sample inputs for rising-edge detection.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      start_q <= 1'b0;
      sw_q    <= '0;
    end else begin
      start_q <= io.START;
      sw_q    <= io.SWITCHES;
    end
  end

  // Edge detect, press judgement, tick period select and tick clear.
  // Only the SPIN exit needs an explicit clear: IDLE holds the counter at zero,
  // and WIN/LOSE leave on a tick, which already wraps the counter to zero.
  always_comb begin
    start_rise = io.START & ~start_q;
    sw_rise    = io.SWITCHES & ~sw_q;
    hit        = is_onehot(32'(sw_rise)) && (sw_rise == leds);
    tc         = (state == SPIN || state == IDLE) ? TC_SPIN : TC_SHOW;
    clr        = (state == IDLE) || ((state == SPIN) && (sw_rise != '0));
  end

  tick_gen u_tick_gen (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .clr   (clr),
    .tc    (tc),
    .tick  (tick)
  );

  // Game state machine with registered LED and status outputs.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      leds     <= '0;
      win_r    <= 1'b0;
      busy_r   <= 1'b0;
      show_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          leds <= '0;
          if (start_rise) begin
            state  <= SPIN;
            leds   <= NLED'(1);
            busy_r <= 1'b1;
          end
        end
        SPIN: begin
          if (sw_rise != '0) begin
            show_cnt <= '0;
            if (hit) begin
              state <= WIN;
              leds  <= '1;
              win_r <= 1'b1;
            end else begin
              state <= LOSE;
            end
          end else if (tick) begin
            leds <= {leds[NLED-2:0], leds[NLED-1]};
          end
        end
        WIN, LOSE: begin
          if (tick) begin
            if (show_cnt == SHOW_TICKS - 32'd1) begin
              state  <= IDLE;
              leds   <= '0;
              win_r  <= 1'b0;
              busy_r <= 1'b0;
            end else begin
              show_cnt <= show_cnt + 32'd1;
              if (state == WIN) begin
                leds <= ~leds;
              end
            end
          end
        end
        default: begin
          state  <= IDLE;
          leds   <= '0;
          win_r  <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jackpot_controller.sv
// Directed bench for jackpot_controller with NLED=4, TC_SPIN=4, TC_SHOW=3, SHOW_TICKS=2.
module tb_jackpot_controller;

  logic CLOCK;
  logic RESET;

  jackpot_if #(.NLED(4)) io ();

  jackpot_controller #(
    .NLED       (4),
    .TC_SPIN    (32'd4),
    .TC_SHOW    (32'd3),
    .SHOW_TICKS (32'd2)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .io    (io)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic       start;
    logic [3:0] sw;
    logic [3:0] leds;
    logic       win;
    logic       busy;
    string      name;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add_n(input int n, input logic st, input logic [3:0] sw,
                                input logic [3:0] leds, input logic win,
                                input logic busy, input string nm);
    vec_t v;
    v.start = st; v.sw = sw; v.leds = leds; v.win = win; v.busy = busy; v.name = nm;
    for (int i = 0; i < n; i++) vt.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [3:0] leds, input logic win,
                       input logic busy);
    n_checks++;
    if ({io.LEDS, io.WIN, io.BUSY} !== {leds, win, busy}) begin
      n_fail++;
      $display("FAIL %s: got leds=%b win=%b busy=%b, expected leds=%b win=%b busy=%b",
               nm, io.LEDS, io.WIN, io.BUSY, leds, win, busy);
    end
  endtask

  // Drive inputs for one cycle, then check outputs after the rising edge.
  task automatic cexp(input logic st, input logic [3:0] sw, input logic [3:0] leds,
                      input logic win, input logic busy, input string nm);
    io.START    = st;
    io.SWITCHES = sw;
    @(posedge CLOCK);
    @(negedge CLOCK);
    check(nm, leds, win, busy);
  endtask

  task automatic spin_to_0010(input string nm);
    cexp(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, {nm, "_start"});
    for (int i = 0; i < 3; i++) cexp(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, {nm, "_p0"});
    cexp(1'b0, 4'b0000, 4'b0010, 1'b0, 1'b1, {nm, "_rot"});
  endtask

  task automatic async_reset(input string nm);
    #2 RESET = 1'b0;
    #1 check(nm, 4'b0000, 1'b0, 1'b0);
    @(negedge CLOCK);
    io.START    = 1'b0;
    io.SWITCHES = 4'b0000;
    RESET       = 1'b1;
    check({nm, "_rel"}, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    // Main run: start, rotate, wrap, win, with ignored START pulses.
    add_n(2, 0, 4'b0000, 4'b0000, 0, 0, "idle");
    add_n(1, 1, 4'b0000, 4'b0001, 0, 1, "start");
    add_n(3, 0, 4'b0000, 4'b0001, 0, 1, "spin_0001");
    add_n(1, 0, 4'b0000, 4'b0010, 0, 1, "rot_0010");
    add_n(1, 1, 4'b0000, 4'b0010, 0, 1, "start_in_spin");
    add_n(2, 0, 4'b0000, 4'b0010, 0, 1, "spin_0010");
    add_n(1, 0, 4'b0000, 4'b0100, 0, 1, "rot_0100");
    add_n(3, 0, 4'b0000, 4'b0100, 0, 1, "spin_0100");
    add_n(1, 0, 4'b0000, 4'b1000, 0, 1, "rot_1000");
    add_n(3, 0, 4'b0000, 4'b1000, 0, 1, "spin_1000");
    add_n(1, 0, 4'b0000, 4'b0001, 0, 1, "wrap_0001");
    add_n(3, 0, 4'b0000, 4'b0001, 0, 1, "spin_0001b");
    add_n(1, 0, 4'b0000, 4'b0010, 0, 1, "rot_0010b");
    add_n(3, 0, 4'b0000, 4'b0010, 0, 1, "spin_0010b");
    add_n(1, 0, 4'b0000, 4'b0100, 0, 1, "rot_0100b");
    add_n(1, 0, 4'b0100, 4'b1111, 1, 1, "win_entry");
    add_n(1, 0, 4'b0100, 4'b1111, 1, 1, "win_1111");
    add_n(1, 1, 4'b0100, 4'b1111, 1, 1, "start_in_win");
    add_n(1, 0, 4'b0100, 4'b0000, 1, 1, "win_invert");
    add_n(2, 0, 4'b0100, 4'b0000, 1, 1, "win_0000");
    add_n(1, 0, 4'b0100, 4'b0000, 0, 0, "win_done");
    add_n(1, 0, 4'b0000, 4'b0000, 0, 0, "idle_after_win");

    RESET       = 1'b0;
    io.START    = 1'b0;
    io.SWITCHES = 4'b0000;
    repeat (3) @(negedge CLOCK);
    check("reset", 4'b0000, 1'b0, 1'b0);
    RESET = 1'b1;

    foreach (vt[i]) cexp(vt[i].start, vt[i].sw, vt[i].leds, vt[i].win, vt[i].busy, vt[i].name);

    // Lose: mismatched single switch.
    spin_to_0010("lose");
    cexp(1'b0, 4'b0001, 4'b0010, 1'b0, 1'b1, "lose_entry");
    for (int i = 0; i < 5; i++) cexp(1'b0, 4'b0001, 4'b0010, 1'b0, 1'b1, "lose_hold");
    cexp(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, "lose_done");
    cexp(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "lose_idle");

    // Multi-press including the lit position is a loss.
    spin_to_0010("multi");
    cexp(1'b0, 4'b0110, 4'b0010, 1'b0, 1'b1, "multi_lose");
    for (int i = 0; i < 5; i++) cexp(1'b0, 4'b0110, 4'b0010, 1'b0, 1'b1, "multi_hold");
    cexp(1'b0, 4'b0110, 4'b0000, 1'b0, 1'b0, "multi_done");
    cexp(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "multi_idle");

    // Collision: matching press in the tick cycle judges against pre-rotate LEDs.
    cexp(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b1, "coll_start");
    for (int i = 0; i < 3; i++) cexp(1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, "coll_spin");
    cexp(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b1, "coll_win");
    for (int i = 0; i < 2; i++) cexp(1'b0, 4'b0001, 4'b1111, 1'b1, 1'b1, "coll_1111");
    for (int i = 0; i < 3; i++) cexp(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, "coll_0000");
    cexp(1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, "coll_done");
    cexp(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, "coll_idle");

    // Switch held from IDLE into SPIN gives no edge.
    cexp(1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, "held_idle");
    cexp(1'b1, 4'b0010, 4'b0001, 1'b0, 1'b1, "held_start");
    for (int i = 0; i < 3; i++) cexp(1'b0, 4'b0010, 4'b0001, 1'b0, 1'b1, "held_p0");
    cexp(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, "held_rot");
    for (int i = 0; i < 3; i++) cexp(1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, "held_p1");
    cexp(1'b0, 4'b0010, 4'b0100, 1'b0, 1'b1, "held_rot2");

    // Asynchronous reset during SPIN, then a full first period.
    async_reset("rst_spin");
    spin_to_0010("post_rst1");

    // Win, then asynchronous reset during WIN.
    cexp(1'b0, 4'b0010, 4'b1111, 1'b1, 1'b1, "win2_entry");
    cexp(1'b0, 4'b0010, 4'b1111, 1'b1, 1'b1, "win2_1111");
    async_reset("rst_win");
    spin_to_0010("post_rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
